// File: rtl/temp_bcd_conv.sv
// ============================================================================
// temp_bcd_conv : 13-bit two's complement temperature word to sign + BCD
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module temp_bcd_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] temp_raw,
  output logic        sign,
  output logic [11:0] bcd_int,
  output logic [15:0] bcd_frac,
  output logic        upd,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_INT_DD  = 3'd2,
    S_FRAC_DD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] INT_LAST  = 4'd8;
  localparam logic [3:0] FRAC_LAST = 4'd13;

  state_t      state_q, state_d;
  logic [12:0] cap_q, cap_d;
  logic        first_q, first_d;
  logic        neg_q, neg_d;
  logic [8:0]  int_bin_q, int_bin_d;
  logic [13:0] frac_bin_q, frac_bin_d;
  logic [11:0] int_acc_q, int_acc_d;
  logic [15:0] frac_acc_q, frac_acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [11:0] bcd_int_q, bcd_int_d;
  logic [15:0] bcd_frac_q, bcd_frac_d;
  logic        upd_q, upd_d;
  logic        valid_q, valid_d;

  logic [12:0] mag;
  logic [13:0] frac_prod;
  logic [15:0] adj;

  // Double-dabble correction step: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] acc);
    logic [15:0] r;
    r = acc;
    for (int n = 0; n < 4; n++) begin
      if (r[n*4 +: 4] >= 4'd5) begin
        r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    first_d    = first_q;
    neg_d      = neg_q;
    int_bin_d  = int_bin_q;
    frac_bin_d = frac_bin_q;
    int_acc_d  = int_acc_q;
    frac_acc_d = frac_acc_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    bcd_int_d  = bcd_int_q;
    bcd_frac_d = bcd_frac_q;
    upd_d      = 1'b0;
    valid_d    = valid_q;
    adj        = 16'd0;

    // Negating -4096 wraps back to 0x1000, which read unsigned is the legal 256.0
    mag       = cap_q[12] ? (~cap_q + 13'd1) : cap_q;
    frac_prod = 14'(mag[3:0]) * 14'd625;

    case (state_q)
      S_IDLE: begin
        if ((temp_raw[15:3] != cap_q) || first_q) begin
          cap_d   = temp_raw[15:3];
          first_d = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        neg_d      = cap_q[12];
        int_bin_d  = mag[12:4];
        frac_bin_d = frac_prod;
        int_acc_d  = 12'd0;
        frac_acc_d = 16'd0;
        cnt_d      = 4'd0;
        state_d    = S_INT_DD;
      end

      S_INT_DD: begin
        adj       = dd_adjust({4'd0, int_acc_q});
        int_acc_d = {adj[10:0], int_bin_q[8]};
        int_bin_d = {int_bin_q[7:0], 1'b0};
        if (cnt_q == INT_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_FRAC_DD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_FRAC_DD: begin
        adj        = dd_adjust(frac_acc_q);
        frac_acc_d = {adj[14:0], frac_bin_q[13]};
        frac_bin_d = {frac_bin_q[12:0], 1'b0};
        if (cnt_q == FRAC_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_DONE: begin
        sign_d     = neg_q;
        bcd_int_d  = int_acc_q;
        bcd_frac_d = frac_acc_q;
        upd_d      = 1'b1;
        valid_d    = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cap_q      <= 13'd0;
      first_q    <= 1'b1;
      neg_q      <= 1'b0;
      int_bin_q  <= 9'd0;
      frac_bin_q <= 14'd0;
      int_acc_q  <= 12'd0;
      frac_acc_q <= 16'd0;
      cnt_q      <= 4'd0;
      sign_q     <= 1'b0;
      bcd_int_q  <= 12'd0;
      bcd_frac_q <= 16'd0;
      upd_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      first_q    <= first_d;
      neg_q      <= neg_d;
      int_bin_q  <= int_bin_d;
      frac_bin_q <= frac_bin_d;
      int_acc_q  <= int_acc_d;
      frac_acc_q <= frac_acc_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      bcd_int_q  <= bcd_int_d;
      bcd_frac_q <= bcd_frac_d;
      upd_q      <= upd_d;
      valid_q    <= valid_d;
    end
  end

  assign sign     = sign_q;
  assign bcd_int  = bcd_int_q;
  assign bcd_frac = bcd_frac_q;
  assign upd      = upd_q;
  assign valid    = valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire
